// File: rtl/lv_hv_adc_rd_req_pkg.sv
// Shared OWT command layout, HV ADC register address and the readback FSM state type
// for the LV-side ADC readback initiator.
package lv_hv_adc_rd_req_pkg;

   localparam int unsigned LV_OWT_CMD_BIT_NUM = 8;
   localparam int unsigned LV_REG_AW          = LV_OWT_CMD_BIT_NUM - 1;

   localparam logic [LV_REG_AW-1:0] LV_ADC_REG_ADDR = 7'h1F;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_RSP = 2'd2,
      ST_GAP      = 2'd3
   } lv_adc_rd_state_e;

endpackage

// File: rtl/lv_hv_adc_rd_req.sv
// LV-side initiator that periodically reads the HV ADC register over OWT, supervising
// reply timeout and retries, and reporting done/error/sticky-fail to LV control.
module lv_hv_adc_rd_req
   import lv_hv_adc_rd_req_pkg::*;
#(
   parameter int unsigned                  OWT_CMD_BIT_NUM = LV_OWT_CMD_BIT_NUM,
   parameter logic [OWT_CMD_BIT_NUM-2:0]   ADC_REG_ADDR    = LV_ADC_REG_ADDR,
   parameter int unsigned                  POLL_PERIOD_CYC = 1000,
   parameter int unsigned                  RSP_TIMEOUT_CYC = 200,
   parameter int unsigned                  MAX_RETRY       = 2
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_poll_en,
   output logic                       o_owt_tx_req,
   output logic [OWT_CMD_BIT_NUM-1:0] o_owt_tx_cmd,
   input  logic                       i_owt_tx_ack,
   input  logic                       i_owt_rx_ack,
   input  logic [OWT_CMD_BIT_NUM-1:0] i_owt_rx_cmd,
   input  logic                       i_owt_rx_status,
   output logic                       o_rd_done,
   output logic                       o_rd_err,
   output logic                       o_comm_fail,
   output logic                       o_busy
);

   localparam int TMO_W   = $clog2(RSP_TIMEOUT_CYC + 1);
   localparam int GAP_W   = $clog2(POLL_PERIOD_CYC + 1);
   localparam int RETRY_W = (MAX_RETRY == 0) ? 1 : $clog2(MAX_RETRY + 1);

   localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(RSP_TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST  = GAP_W'(POLL_PERIOD_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   localparam logic [OWT_CMD_BIT_NUM-1:0] RD_CMD  = {1'b0, ADC_REG_ADDR};
   localparam logic [OWT_CMD_BIT_NUM-1:0] RSP_CMD = {1'b1, ADC_REG_ADDR};

   lv_adc_rd_state_e state, state_nxt;

   logic [TMO_W-1:0]   tmo_cnt;
   logic [GAP_W-1:0]   gap_cnt;
   logic [RETRY_W-1:0] retry_cnt;

   logic rsp_match;
   logic ok_evt;
   logic fail_evt;
   logic retry_exhausted;
   logic final_fail;

   // A good reply wins over a timeout landing in the same cycle.
   assign rsp_match       = i_owt_rx_ack & ~i_owt_rx_status & (i_owt_rx_cmd == RSP_CMD);
   assign ok_evt          = (state == ST_WAIT_RSP) & rsp_match;
   assign fail_evt        = (state == ST_WAIT_RSP) & ~rsp_match &
                            ((i_owt_rx_ack & i_owt_rx_status) | (tmo_cnt == TMO_LAST));
   assign retry_exhausted = (retry_cnt >= RETRY_MAX);
   assign final_fail      = fail_evt & retry_exhausted;

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: begin
            if (i_poll_en) state_nxt = ST_REQ;
         end
         ST_REQ: begin
            if (i_owt_tx_ack) state_nxt = ST_WAIT_RSP;
         end
         ST_WAIT_RSP: begin
            if (ok_evt || final_fail) state_nxt = i_poll_en ? ST_GAP : ST_IDLE;
            else if (fail_evt)        state_nxt = ST_REQ;
         end
         ST_GAP: begin
            if (!i_poll_en)               state_nxt = ST_IDLE;
            else if (gap_cnt == GAP_LAST) state_nxt = ST_REQ;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Counters clear outside their own state and saturate rather than wrap.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         tmo_cnt     <= '0;
         gap_cnt     <= '0;
         retry_cnt   <= '0;
         o_rd_done   <= 1'b0;
         o_rd_err    <= 1'b0;
         o_comm_fail <= 1'b0;
      end else begin
         state     <= state_nxt;
         o_rd_done <= ok_evt;
         o_rd_err  <= final_fail;

         if (ok_evt)          o_comm_fail <= 1'b0;
         else if (final_fail) o_comm_fail <= 1'b1;

         if (state != ST_WAIT_RSP)  tmo_cnt <= '0;
         else if (tmo_cnt != TMO_LAST) tmo_cnt <= tmo_cnt + 1'b1;

         if (state != ST_GAP)          gap_cnt <= '0;
         else if (gap_cnt != GAP_LAST) gap_cnt <= gap_cnt + 1'b1;

         if (ok_evt || final_fail) retry_cnt <= '0;
         else if (fail_evt)        retry_cnt <= retry_cnt + 1'b1;
      end
   end

   assign o_owt_tx_req = (state == ST_REQ);
   assign o_owt_tx_cmd = o_owt_tx_req ? RD_CMD : '0;
   assign o_busy       = (state == ST_REQ) || (state == ST_WAIT_RSP);

endmodule

// File: tb/tb_lv_hv_adc_rd_req.sv
// Directed bench for lv_hv_adc_rd_req: a cycle table for reset and the basic poll loop,
// followed by hand-written retry, timeout, poll-disable and reset sequences.
module tb_lv_hv_adc_rd_req;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       poll_en;
   logic       tx_req;
   logic [7:0] tx_cmd;
   logic       tx_ack;
   logic       rx_ack;
   logic [7:0] rx_cmd;
   logic       rx_status;
   logic       rd_done;
   logic       rd_err;
   logic       comm_fail;
   logic       busy;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   lv_hv_adc_rd_req #(
      .OWT_CMD_BIT_NUM (8),
      .ADC_REG_ADDR    (7'h1F),
      .POLL_PERIOD_CYC (10),
      .RSP_TIMEOUT_CYC (8),
      .MAX_RETRY       (2)
   ) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_poll_en       (poll_en),
      .o_owt_tx_req    (tx_req),
      .o_owt_tx_cmd    (tx_cmd),
      .i_owt_tx_ack    (tx_ack),
      .i_owt_rx_ack    (rx_ack),
      .i_owt_rx_cmd    (rx_cmd),
      .i_owt_rx_status (rx_status),
      .o_rd_done       (rd_done),
      .o_rd_err        (rd_err),
      .o_comm_fail     (comm_fail),
      .o_busy          (busy)
   );

   typedef struct {
      logic       rst_n;
      logic       poll_en;
      logic       tx_ack;
      logic       rx_ack;
      logic [7:0] rx_cmd;
      logic       rx_status;
      logic       exp_req;
      logic [7:0] exp_cmd;
      logic       exp_busy;
      logic       exp_done;
      logic       exp_err;
      logic       exp_fail;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic r, input logic p, input logic ta, input logic ra,
                          input logic [7:0] rc, input logic rs, input logic e_req,
                          input logic e_busy, input logic e_done, input logic e_err,
                          input logic e_fail);
      vec_t v;
      v.rst_n = r; v.poll_en = p; v.tx_ack = ta; v.rx_ack = ra;
      v.rx_cmd = rc; v.rx_status = rs;
      v.exp_req = e_req; v.exp_cmd = e_req ? 8'h1F : 8'h00;
      v.exp_busy = e_busy; v.exp_done = e_done; v.exp_err = e_err; v.exp_fail = e_fail;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input int act, input int exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic apply_stimulus(input vec_t v);
      rst_n     = v.rst_n;
      poll_en   = v.poll_en;
      tx_ack    = v.tx_ack;
      rx_ack    = v.rx_ack;
      rx_cmd    = v.rx_cmd;
      rx_status = v.rx_status;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; poll_en = 1'b0; tx_ack = 1'b0;
      rx_ack = 1'b0; rx_cmd = 8'h00; rx_status = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!tx_req && n < 50) begin
         step();
         n++;
      end
      check_output(tag, int'(tx_req), 1);
   endtask

   task automatic pulse_tx_ack();
      tx_ack = 1'b1;
      step();
      tx_ack = 1'b0;
   endtask

   task automatic pulse_rx(input logic [7:0] cmd, input logic status);
      rx_ack = 1'b1; rx_cmd = cmd; rx_status = status;
      step();
      rx_ack = 1'b0; rx_cmd = 8'h00; rx_status = 1'b0;
   endtask

   // Counts cycles spent in WAIT_RSP (busy with no request) from the current sample on.
   task automatic count_wait(input int start, output int n);
      n = start;
      while (busy && !tx_req && n < 20) begin
         n++;
         step();
      end
   endtask

   initial begin
      int n;
      int req_seen;

      rst_n = 1'b0; poll_en = 1'b0; tx_ack = 1'b0;
      rx_ack = 1'b0; rx_cmd = 8'h00; rx_status = 1'b0;

      // Reset ignores poll_en, then the basic poll loop with a 10-cycle gap.
      add_vec(0,1,0,0,8'h00,0, 0,0,0,0,0);
      add_vec(0,1,0,0,8'h00,0, 0,0,0,0,0);
      add_vec(1,1,0,0,8'h00,0, 1,1,0,0,0);
      add_vec(1,1,0,0,8'h00,0, 1,1,0,0,0);
      add_vec(1,1,0,0,8'h00,0, 1,1,0,0,0);
      add_vec(1,1,1,0,8'h00,0, 0,1,0,0,0);
      for (int i = 0; i < 4; i++) add_vec(1,1,0,0,8'h00,0, 0,1,0,0,0);
      add_vec(1,1,0,1,8'h9F,0, 0,0,1,0,0);
      for (int i = 0; i < 9; i++) add_vec(1,1,0,0,8'h00,0, 0,0,0,0,0);
      add_vec(1,1,0,0,8'h00,0, 1,1,0,0,0);
      add_vec(1,0,0,0,8'h00,0, 1,1,0,0,0);
      add_vec(1,0,1,0,8'h00,0, 0,1,0,0,0);
      add_vec(1,0,0,1,8'h9F,0, 0,0,1,0,0);
      add_vec(1,0,0,0,8'h00,0, 0,0,0,0,0);

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         step();
         check_output($sformatf("vec%0d req", i),  int'(tx_req),    int'(vecs[i].exp_req));
         check_output($sformatf("vec%0d cmd", i),  int'(tx_cmd),    int'(vecs[i].exp_cmd));
         check_output($sformatf("vec%0d busy", i), int'(busy),      int'(vecs[i].exp_busy));
         check_output($sformatf("vec%0d done", i), int'(rd_done),   int'(vecs[i].exp_done));
         check_output($sformatf("vec%0d err", i),  int'(rd_err),    int'(vecs[i].exp_err));
         check_output($sformatf("vec%0d fail", i), int'(comm_fail), int'(vecs[i].exp_fail));
      end

      // No replies at all: three 8-cycle attempts, then error and sticky fail.
      do_reset();
      poll_en = 1'b1;
      for (int a = 0; a < 3; a++) begin
         wait_req($sformatf("s2 req%0d", a));
         check_output($sformatf("s2 cmd%0d", a), int'(tx_cmd), 8'h1F);
         pulse_tx_ack();
         count_wait(0, n);
         check_output($sformatf("s2 wait%0d", a), n, 8);
         check_output($sformatf("s2 err%0d", a), int'(rd_err), (a == 2) ? 1 : 0);
         check_output($sformatf("s2 fail%0d", a), int'(comm_fail), (a == 2) ? 1 : 0);
      end
      check_output("s2 gap busy", int'(busy), 0);
      step();
      check_output("s2 err pulse", int'(rd_err), 0);
      check_output("s2 fail sticky", int'(comm_fail), 1);
      wait_req("s2 req after gap");
      pulse_tx_ack();
      step();
      pulse_rx(8'h9F, 1'b0);
      check_output("s2 recover done", int'(rd_done), 1);
      check_output("s2 recover fail", int'(comm_fail), 0);

      // Errored reply forces one retry; the retry succeeds.
      do_reset();
      poll_en = 1'b1;
      wait_req("s3 req");
      pulse_tx_ack();
      pulse_rx(8'h9F, 1'b1);
      check_output("s3 retry req", int'(tx_req), 1);
      check_output("s3 no done", int'(rd_done), 0);
      check_output("s3 no err", int'(rd_err), 0);
      pulse_tx_ack();
      pulse_rx(8'h9F, 1'b0);
      check_output("s3 done", int'(rd_done), 1);
      check_output("s3 err", int'(rd_err), 0);
      check_output("s3 fail", int'(comm_fail), 0);

      // Reply for another register is ignored; the timeout still fires on schedule.
      do_reset();
      poll_en = 1'b1;
      wait_req("s4 req");
      pulse_tx_ack();
      pulse_rx(8'h95, 1'b0);
      check_output("s4 ignored done", int'(rd_done), 0);
      check_output("s4 still waiting", int'(busy), 1);
      count_wait(1, n);
      check_output("s4 wait len", n, 8);
      check_output("s4 retry req", int'(tx_req), 1);
      check_output("s4 no err", int'(rd_err), 0);

      // poll_en dropped while requesting; reply arrives on the timeout cycle.
      do_reset();
      poll_en = 1'b1;
      wait_req("s5 req");
      poll_en = 1'b0;
      repeat (4) step();
      check_output("s5 req held", int'(tx_req), 1);
      pulse_tx_ack();
      repeat (7) step();
      check_output("s5 still waiting", int'(busy), 1);
      pulse_rx(8'h9F, 1'b0);
      check_output("s5 done", int'(rd_done), 1);
      check_output("s5 no err", int'(rd_err), 0);
      check_output("s5 no retry", int'(tx_req), 0);
      req_seen = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (tx_req || busy) req_seen++;
      end
      check_output("s5 stays idle", req_seen, 0);

      // Reset in WAIT_RSP aborts; a late reply must not complete anything.
      do_reset();
      poll_en = 1'b1;
      wait_req("s6 req");
      pulse_tx_ack();
      repeat (2) step();
      rst_n = 1'b0;
      step();
      check_output("s6 rst req", int'(tx_req), 0);
      check_output("s6 rst cmd", int'(tx_cmd), 0);
      check_output("s6 rst busy", int'(busy), 0);
      check_output("s6 rst done", int'(rd_done), 0);
      check_output("s6 rst err", int'(rd_err), 0);
      check_output("s6 rst fail", int'(comm_fail), 0);
      rst_n = 1'b1;
      poll_en = 1'b0;
      step();
      pulse_rx(8'h9F, 1'b0);
      check_output("s6 late done", int'(rd_done), 0);
      check_output("s6 late busy", int'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
